// File: rtl/axis2xgmii32.sv
`default_nettype none
//==============================================================================
// Module  : axis2xgmii32
// Brief   : 32-bit AXIS to XGMII TX framer: preamble/SFD, zero padding,
//           FCS append, terminate character and inter-frame gap.
// Revision: 1.0
//==============================================================================
module axis2xgmii32 #(
    parameter int IFG_WORDS   = 3,
    parameter bit PAD_EN      = 1'b1,
    parameter int MIN_PAYLOAD = 60
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] tdata_i,
    input  logic [1:0]  tvldb_i,
    input  logic        tvalid_i,
    input  logic        tlast_i,
    output logic        tready_o,
    input  logic        xgmii_rdy_i,
    output logic [31:0] xgmii_d_o,
    output logic [3:0]  xgmii_c_o,
    output logic [31:0] frames_o,
    output logic [31:0] underruns_o
);

    localparam logic [3:0] c_ST_IDLE  = 4'd0;
    localparam logic [3:0] c_ST_SFD   = 4'd1;
    localparam logic [3:0] c_ST_DATA  = 4'd2;
    localparam logic [3:0] c_ST_PAD   = 4'd3;
    localparam logic [3:0] c_ST_TAIL  = 4'd4;
    localparam logic [3:0] c_ST_TERM  = 4'd5;
    localparam logic [3:0] c_ST_ABORT = 4'd6;
    localparam logic [3:0] c_ST_FLUSH = 4'd7;
    localparam logic [3:0] c_ST_IFG   = 4'd8;

    localparam logic [31:0] c_IDLE_D      = 32'h07070707;
    localparam logic [31:0] c_START_D     = 32'h555555FB;
    localparam logic [31:0] c_PREAMBLE_D  = 32'h55555555;
    localparam logic [31:0] c_SFD_D       = 32'hD5555555;
    localparam logic [31:0] c_ERROR_D     = 32'hFEFEFEFE;
    localparam logic [31:0] c_TERM0_D     = 32'h070707FD;
    localparam logic [15:0] c_MIN_PAYLOAD = 16'(MIN_PAYLOAD);
    localparam logic [7:0]  c_IFG_WORDS   = 8'(IFG_WORDS);
    localparam logic [3:0]  c_AFTER_TERM  = (IFG_WORDS == 0) ? c_ST_IDLE : c_ST_IFG;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] v;
        v = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++)
            v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
        return v;
    endfunction

    function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] d);
        logic [31:0] v;
        v = crc;
        for (int i = 0; i < 4; i++)
            v = crc32_byte(v, d[8*i +: 8]);
        return v;
    endfunction

    logic [3:0]  r_state;
    logic [31:0] r_d;
    logic [3:0]  r_c;
    logic [31:0] r_crc;
    logic [15:0] r_cnt;
    logic [31:0] r_term_d;
    logic [3:0]  r_term_c;
    logic [7:0]  r_ifg_cnt;
    logic [31:0] r_frames;
    logic [31:0] r_underruns;

    logic [3:0]  w_lane_en;
    logic [31:0] w_data_m;
    logic [2:0]  w_nbytes;
    logic [16:0] w_sum_n;
    logic [16:0] w_sum_4;
    logic [15:0] w_cnt_add;
    logic [15:0] w_cnt_fill;
    logic        w_pad_needed;
    logic [31:0] w_crc_b1;
    logic [31:0] w_crc_b2;
    logic [31:0] w_crc_b3;
    logic [31:0] w_crc_b4;
    logic [31:0] w_crc_pad;
    logic [31:0] w_fcs1;
    logic [31:0] w_fcs2;
    logic [31:0] w_fcs3;

    // Lanes beyond the last valid byte are zeroed so the padded CRC sees 0x00.
    always_comb begin
        w_lane_en = 4'b1111;
        if (tlast_i) begin
            case (tvldb_i)
                2'd0:    w_lane_en = 4'b0001;
                2'd1:    w_lane_en = 4'b0011;
                2'd2:    w_lane_en = 4'b0111;
                default: w_lane_en = 4'b1111;
            endcase
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
        assign w_data_m[8*gi +: 8] = w_lane_en[gi] ? tdata_i[8*gi +: 8] : 8'h00;
    end

    assign w_nbytes     = tlast_i ? ({1'b0, tvldb_i} + 3'd1) : 3'd4;
    assign w_sum_n      = {1'b0, r_cnt} + {14'd0, w_nbytes};
    assign w_sum_4      = {1'b0, r_cnt} + 17'd4;
    assign w_cnt_add    = w_sum_n[16] ? 16'hFFFF : w_sum_n[15:0];
    assign w_cnt_fill   = w_sum_4[16] ? 16'hFFFF : w_sum_4[15:0];
    assign w_pad_needed = PAD_EN && (w_cnt_add < c_MIN_PAYLOAD);

    assign w_crc_b1  = crc32_byte(r_crc,    w_data_m[7:0]);
    assign w_crc_b2  = crc32_byte(w_crc_b1, w_data_m[15:8]);
    assign w_crc_b3  = crc32_byte(w_crc_b2, w_data_m[23:16]);
    assign w_crc_b4  = crc32_byte(w_crc_b3, w_data_m[31:24]);
    assign w_crc_pad = crc32_word(r_crc, 32'd0);
    assign w_fcs1    = ~w_crc_b1;
    assign w_fcs2    = ~w_crc_b2;
    assign w_fcs3    = ~w_crc_b3;

    assign tready_o    = xgmii_rdy_i && ((r_state == c_ST_DATA) || (r_state == c_ST_FLUSH));
    assign xgmii_d_o   = r_d;
    assign xgmii_c_o   = r_c;
    assign frames_o    = r_frames;
    assign underruns_o = r_underruns;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_IDLE;
            r_d         <= c_IDLE_D;
            r_c         <= 4'hF;
            r_crc       <= 32'hFFFFFFFF;
            r_cnt       <= 16'd0;
            r_term_d    <= c_TERM0_D;
            r_term_c    <= 4'hF;
            r_ifg_cnt   <= 8'd0;
            r_frames    <= 32'd0;
            r_underruns <= 32'd0;
        end else if (xgmii_rdy_i) begin
            case (r_state)
                c_ST_IDLE: begin
                    r_d <= c_IDLE_D;
                    r_c <= 4'hF;
                    if (tvalid_i) begin
                        r_d     <= c_START_D;
                        r_c     <= 4'b0001;
                        r_crc   <= 32'hFFFFFFFF;
                        r_cnt   <= 16'd0;
                        r_state <= c_ST_SFD;
                    end
                end
                // Keep sending plain preamble until the source has data ready.
                c_ST_SFD: begin
                    r_c <= 4'b0000;
                    if (tvalid_i) begin
                        r_d     <= c_SFD_D;
                        r_state <= c_ST_DATA;
                    end else begin
                        r_d <= c_PREAMBLE_D;
                    end
                end
                c_ST_DATA: begin
                    if (!tvalid_i) begin
                        r_d     <= c_ERROR_D;
                        r_c     <= 4'hF;
                        r_state <= c_ST_ABORT;
                    end else begin
                        r_d   <= tdata_i;
                        r_c   <= 4'b0000;
                        r_crc <= w_crc_b4;
                        r_cnt <= w_cnt_add;
                        if (tlast_i) begin
                            if (w_pad_needed) begin
                                r_d     <= w_data_m;
                                r_cnt   <= w_cnt_fill;
                                r_state <= (w_cnt_fill >= c_MIN_PAYLOAD) ? c_ST_TAIL : c_ST_PAD;
                            end else begin
                                case (tvldb_i)
                                    2'd0: begin
                                        r_d      <= {w_fcs1[23:0], tdata_i[7:0]};
                                        r_term_d <= {8'h07, 8'h07, 8'hFD, w_fcs1[31:24]};
                                        r_term_c <= 4'b1110;
                                        r_state  <= c_ST_TERM;
                                    end
                                    2'd1: begin
                                        r_d      <= {w_fcs2[15:0], tdata_i[15:0]};
                                        r_term_d <= {8'h07, 8'hFD, w_fcs2[31:16]};
                                        r_term_c <= 4'b1100;
                                        r_state  <= c_ST_TERM;
                                    end
                                    2'd2: begin
                                        r_d      <= {w_fcs3[7:0], tdata_i[23:0]};
                                        r_term_d <= {8'hFD, w_fcs3[31:8]};
                                        r_term_c <= 4'b1000;
                                        r_state  <= c_ST_TERM;
                                    end
                                    default: r_state <= c_ST_TAIL;
                                endcase
                            end
                        end
                    end
                end
                c_ST_PAD: begin
                    r_d   <= 32'd0;
                    r_c   <= 4'b0000;
                    r_crc <= w_crc_pad;
                    r_cnt <= w_cnt_fill;
                    if (w_cnt_fill >= c_MIN_PAYLOAD)
                        r_state <= c_ST_TAIL;
                end
                c_ST_TAIL: begin
                    r_d      <= ~r_crc;
                    r_c      <= 4'b0000;
                    r_term_d <= c_TERM0_D;
                    r_term_c <= 4'hF;
                    r_state  <= c_ST_TERM;
                end
                c_ST_TERM: begin
                    r_d       <= r_term_d;
                    r_c       <= r_term_c;
                    r_frames  <= r_frames + 32'd1;
                    r_ifg_cnt <= c_IFG_WORDS;
                    r_state   <= c_AFTER_TERM;
                end
                // An underrun can only occur before tlast, so the tail is always flushed.
                c_ST_ABORT: begin
                    r_d         <= c_TERM0_D;
                    r_c         <= 4'hF;
                    r_underruns <= r_underruns + 32'd1;
                    r_state     <= c_ST_FLUSH;
                end
                c_ST_FLUSH: begin
                    r_d <= c_IDLE_D;
                    r_c <= 4'hF;
                    if (tvalid_i && tlast_i) begin
                        r_ifg_cnt <= c_IFG_WORDS;
                        r_state   <= c_AFTER_TERM;
                    end
                end
                c_ST_IFG: begin
                    r_d       <= c_IDLE_D;
                    r_c       <= 4'hF;
                    r_ifg_cnt <= r_ifg_cnt - 8'd1;
                    if (r_ifg_cnt <= 8'd1)
                        r_state <= c_ST_IDLE;
                end
                default: begin
                    r_d     <= c_IDLE_D;
                    r_c     <= 4'hF;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis2xgmii32.sv
`default_nettype none
//==============================================================================
// Module  : tb_axis2xgmii32
// Brief   : Directed self-checking bench for the axis2xgmii32 TX framer.
// Revision: 1.0
//==============================================================================
module tb_axis2xgmii32;

    localparam int          c_IFG   = 3;
    localparam int          c_MIN   = 60;
    localparam logic [35:0] c_START = {4'b0001, 32'h555555FB};
    localparam logic [35:0] c_IDLE  = {4'hF, 32'h07070707};

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] tdata_i = 32'd0;
    logic [1:0]  tvldb_i = 2'd0;
    logic        tvalid_i = 1'b0;
    logic        tlast_i = 1'b0;
    logic        tready_o;
    logic        xgmii_rdy_i = 1'b1;
    logic [31:0] xgmii_d_o;
    logic [3:0]  xgmii_c_o;
    logic [31:0] frames_o;
    logic [31:0] underruns_o;

    int checks = 0;
    int passed = 0;
    bit stall_en = 1'b0;

    logic [7:0]  frame_b [0:2047];
    logic [7:0]  wb      [0:2047];
    logic [35:0] cap_q[$];
    logic [35:0] exp_q[$];

    axis2xgmii32 #(.IFG_WORDS(c_IFG), .PAD_EN(1'b1), .MIN_PAYLOAD(c_MIN)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .tdata_i     (tdata_i),
        .tvldb_i     (tvldb_i),
        .tvalid_i    (tvalid_i),
        .tlast_i     (tlast_i),
        .tready_o    (tready_o),
        .xgmii_rdy_i (xgmii_rdy_i),
        .xgmii_d_o   (xgmii_d_o),
        .xgmii_c_o   (xgmii_c_o),
        .frames_o    (frames_o),
        .underruns_o (underruns_o)
    );

    always #5 clk_i = ~clk_i;

    // Gearbox model: a word is consumed at each rising edge with rdy high.
    initial begin
        int ctr = 0;
        forever begin
            @(posedge clk_i);
            #1;
            ctr++;
            xgmii_rdy_i = !(stall_en && (ctr % 33 == 0));
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i && xgmii_rdy_i)
                cap_q.push_back({xgmii_c_o, xgmii_d_o});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d checks=%0d", passed, checks);
        $fatal(1);
    end

    function automatic logic [31:0] ref_crc(input logic [31:0] crc_in, input logic [7:0] b);
        logic [31:0] c;
        c = crc_in;
        for (int k = 0; k < 8; k++) begin
            if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    task automatic fill_frame(input int len, input int seed);
        for (int i = 0; i < len; i++)
            frame_b[i] = 8'((i * 7 + seed * 13 + 1) & 255);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ready(input string name);
        bit ok = 1'b0;
        int n  = 0;
        while (!ok && n < 500) begin
            @(negedge clk_i);
            ok = tready_o;
            @(posedge clk_i);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            $display("FAIL %s_beat_timeout: tready stayed 0 for %0d cycles, required 1", name, n);
        end
    endtask

    // Beat numbered drop_at is preceded by one cycle with tvalid low.
    task automatic send_frame(input string name, input int len, input int drop_at);
        int nb = (len + 3) / 4;
        for (int b = 0; b < nb; b++) begin
            if (b == drop_at) begin
                tvalid_i = 1'b0;
                @(posedge clk_i);
                #1;
            end
            for (int l = 0; l < 4; l++)
                tdata_i[8*l +: 8] = (b * 4 + l < len) ? frame_b[b * 4 + l] : 8'hA5;
            tlast_i  = (b == nb - 1);
            tvldb_i  = tlast_i ? 2'((len - 1) % 4) : 2'(b);
            tvalid_i = 1'b1;
            wait_ready(name);
        end
        tvalid_i = 1'b0;
        tlast_i  = 1'b0;
    endtask

    // Wire-level model: preamble, padded payload, FCS, /T/ and idle fill, then IFG idles.
    task automatic build_exp(input int len);
        int plen;
        int t;
        int total;
        logic [31:0] crc;
        logic [31:0] d;
        logic [3:0]  c;
        exp_q.delete();
        exp_q.push_back(c_START);
        exp_q.push_back({4'b0000, 32'hD5555555});
        plen = (len < c_MIN) ? c_MIN : len;
        crc  = 32'hFFFFFFFF;
        for (int i = 0; i < plen; i++) begin
            wb[i] = (i < len) ? frame_b[i] : 8'h00;
            crc   = ref_crc(crc, wb[i]);
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++)
            wb[plen + k] = crc[8*k +: 8];
        t     = plen + 4;
        total = ((t + 4) / 4) * 4;
        wb[t] = 8'hFD;
        for (int j = t + 1; j < total; j++)
            wb[j] = 8'h07;
        for (int w = 0; w < total / 4; w++) begin
            for (int l = 0; l < 4; l++) begin
                d[8*l +: 8] = wb[4 * w + l];
                c[l]        = (4 * w + l >= t);
            end
            exp_q.push_back({c, d});
        end
        for (int k = 0; k < c_IFG; k++)
            exp_q.push_back(c_IDLE);
    endtask

    task automatic check_stream(input string name, input int from, output int next_idx);
        int s = -1;
        logic [35:0] got;
        for (int i = from; i < cap_q.size(); i++)
            if (s < 0 && cap_q[i] == c_START) s = i;
        checks++;
        if (s < 0) begin
            $display("FAIL %s_start: no start word among %0d captured words, required %h", name, cap_q.size(), c_START);
            next_idx = from;
            return;
        end
        passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (s + i < cap_q.size()) ? cap_q[s + i] : 36'hxxxxxxxxx;
            checks++;
            if (got !== exp_q[i])
                $display("FAIL %s_word%0d: got c=%h d=%h, required c=%h d=%h", name, i, got[35:32], got[31:0], exp_q[i][35:32], exp_q[i][31:0]);
            else
                passed++;
        end
        next_idx = s + exp_q.size();
    endtask

    task automatic check_counters(input string name, input logic [31:0] fr, input logic [31:0] ur);
        checks++;
        if (frames_o !== fr) $display("FAIL %s_frames: got %0d, required %0d", name, frames_o, fr);
        else passed++;
        checks++;
        if (underruns_o !== ur) $display("FAIL %s_underruns: got %0d, required %0d", name, underruns_o, ur);
        else passed++;
    endtask

    task automatic check_idle_out(input string name);
        @(negedge clk_i);
        checks++;
        if (xgmii_d_o !== 32'h07070707) $display("FAIL %s_d: got %h, required 07070707", name, xgmii_d_o);
        else passed++;
        checks++;
        if (xgmii_c_o !== 4'hF) $display("FAIL %s_c: got %h, required f", name, xgmii_c_o);
        else passed++;
        checks++;
        if (tready_o !== 1'b0) $display("FAIL %s_tready: got %b, required 0", name, tready_o);
        else passed++;
        check_counters(name, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        wait_cycles(3);
        check_idle_out("reset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_pad();
        int nx;
        cap_q.delete();
        fill_frame(8, 1);
        send_frame("pad8", 8, -1);
        wait_cycles(40);
        build_exp(8);
        check_stream("pad8", 0, nx);
        check_counters("pad8", 32'd1, 32'd0);
    endtask

    task automatic test_lengths();
        int lens [6] = '{61, 62, 63, 64, 57, 5};
        int nx;
        for (int i = 0; i < 6; i++) begin
            cap_q.delete();
            fill_frame(lens[i], i + 2);
            send_frame($sformatf("len%0d", lens[i]), lens[i], -1);
            wait_cycles(40);
            build_exp(lens[i]);
            check_stream($sformatf("len%0d", lens[i]), 0, nx);
        end
        check_counters("lengths", 32'd7, 32'd0);
    endtask

    task automatic test_underrun();
        int nx;
        cap_q.delete();
        fill_frame(32, 9);
        send_frame("underrun", 32, 2);
        wait_cycles(20);
        exp_q.delete();
        exp_q.push_back(c_START);
        exp_q.push_back({4'b0000, 32'hD5555555});
        exp_q.push_back({4'b0000, frame_b[3], frame_b[2], frame_b[1], frame_b[0]});
        exp_q.push_back({4'b0000, frame_b[7], frame_b[6], frame_b[5], frame_b[4]});
        exp_q.push_back({4'hF, 32'hFEFEFEFE});
        exp_q.push_back({4'hF, 32'h070707FD});
        for (int k = 0; k < c_IFG; k++)
            exp_q.push_back(c_IDLE);
        check_stream("underrun", 0, nx);
        check_counters("underrun", 32'd7, 32'd1);
    endtask

    task automatic test_stall();
        int nx;
        cap_q.delete();
        fill_frame(1500, 5);
        stall_en = 1'b1;
        send_frame("stall", 1500, -1);
        wait_cycles(40);
        stall_en = 1'b0;
        wait_cycles(2);
        build_exp(1500);
        check_stream("stall", 0, nx);
        check_counters("stall", 32'd8, 32'd1);
    endtask

    task automatic test_back_to_back();
        int nx;
        int nx2;
        cap_q.delete();
        fill_frame(64, 3);
        send_frame("b2b_a", 64, -1);
        send_frame("b2b_b", 64, -1);
        wait_cycles(40);
        build_exp(64);
        check_stream("b2b_a", 0, nx);
        checks++;
        if (nx >= cap_q.size() || cap_q[nx] !== c_START)
            $display("FAIL b2b_gap: word after %0d idles is %h, required %h", c_IFG, (nx < cap_q.size()) ? cap_q[nx] : 36'hxxxxxxxxx, c_START);
        else
            passed++;
        check_stream("b2b_b", nx, nx2);
        check_counters("b2b", 32'd10, 32'd1);
    endtask

    task automatic test_reset_mid();
        fill_frame(16, 4);
        tdata_i  = {frame_b[3], frame_b[2], frame_b[1], frame_b[0]};
        tvldb_i  = 2'd3;
        tlast_i  = 1'b0;
        tvalid_i = 1'b1;
        wait_cycles(5);
        checks++;
        if (tready_o !== 1'b1) $display("FAIL rstmid_in_data: tready got %b, required 1", tready_o);
        else passed++;
        rst_i = 1'b1;
        @(posedge clk_i);
        tvalid_i = 1'b0;
        check_idle_out("rstmid");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        wait_cycles(2);
    endtask

    initial begin
        test_reset();
        test_pad();
        test_lengths();
        test_underrun();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
